// File: rtl/requant_per_channel.sv
// requant_per_channel: 4-stage per-channel int32 -> signed OUT_W requantizer (SRDHM + rounding shift).
// Define REQUANT_SAT_CNT_EN to enable the saturated-lane counter on sat_cnt.
module requant_per_channel #(
   parameter int LANES    = 4,
   parameter int OUT_W    = 8,
   parameter int CH_DEPTH = 64,
   localparam int AW      = $clog2(CH_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*32-1:0]       in_data,
   input  logic [AW-1:0]             in_ch,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*OUT_W-1:0]    out_data,
   input  logic signed [31:0]        out_zp,
   input  logic signed [OUT_W-1:0]   act_min,
   input  logic signed [OUT_W-1:0]   act_max,
   input  logic                      cfg_we,
   input  logic [AW-1:0]             cfg_addr,
   input  logic [31:0]               cfg_mult,
   input  logic signed [5:0]         cfg_shift,
   input  logic                      sat_clr,
   output logic [31:0]               sat_cnt
);
   logic [31:0]        mult_tab  [CH_DEPTH];
   logic signed [5:0]  shift_tab [CH_DEPTH];
   logic signed [5:0]  cfg_shift_clamped;
   logic               stall;
   logic               s1_valid_reg, s2_valid_reg, s3_valid_reg, out_valid_reg;
   logic [LANES-1:0]   sat_vec;

   assign stall     = out_valid_reg && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = out_valid_reg;

   always_comb begin
      cfg_shift_clamped = cfg_shift;
      if (cfg_shift > 6'sd30)
         cfg_shift_clamped = 6'sd30;
      else if (cfg_shift < -6'sd31)
         cfg_shift_clamped = -6'sd31;
   end

   // Table reads are combinational from the flops, so a same-cycle write is seen one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CH_DEPTH; i++) begin
            mult_tab[i]  <= 32'h4000_0000;
            shift_tab[i] <= 6'sd1;
         end
      end else if (cfg_we) begin
         mult_tab[cfg_addr]  <= cfg_mult;
         shift_tab[cfg_addr] <= cfg_shift_clamped;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s2_valid_reg  <= 1'b0;
         s3_valid_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
      end else if (!stall) begin
         s1_valid_reg  <= in_valid;
         s2_valid_reg  <= s1_valid_reg;
         s3_valid_reg  <= s2_valid_reg;
         out_valid_reg <= s3_valid_reg;
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [AW-1:0]       idx;
      logic signed [5:0]   sh;
      logic [4:0]          l_amt, r_amt;
      logic signed [31:0]  x, a_next;
      logic signed [31:0]  a_reg, m_reg, h_reg;
      logic [4:0]          r1_reg, r2_reg, r3_reg;
      logic signed [63:0]  a64, m64, p_reg, sum, h64;
      logic                ovf_reg;
      logic signed [31:0]  h_next, q;
      logic [31:0]         mask, rem, thr;
      logic signed [32:0]  y, lo, hi;
      logic [OUT_W-1:0]    res_next, res_reg;
      logic                sat_next, sat_reg;

      assign idx    = in_ch + AW'(gi);
      assign sh     = shift_tab[idx];
      assign l_amt  = (sh > 6'sd0) ? sh[4:0] : 5'd0;
      assign r_amt  = (sh < 6'sd0) ? 5'(-sh) : 5'd0;
      assign x      = in_data[gi*32 +: 32];
      assign a_next = x << l_amt;

      assign a64 = a_reg;
      assign m64 = m_reg;

      // Round-half-away nudge, then divide by 2^31 truncating toward zero.
      assign sum    = p_reg + (p_reg[63] ? -64'sd1073741823 : 64'sd1073741824);
      assign h64    = sum[63] ? ((sum + 64'sd2147483647) >>> 31) : (sum >>> 31);
      assign h_next = ovf_reg ? 32'sh7FFF_FFFF : h64[31:0];

      assign mask = (32'd1 << r3_reg) - 32'd1;
      assign rem  = h_reg & mask;
      assign thr  = (mask >> 1) + {31'd0, h_reg[31]};
      assign q    = (h_reg >>> r3_reg) + ((rem > thr) ? 32'sd1 : 32'sd0);
      assign y    = {q[31], q} + {out_zp[31], out_zp};
      assign lo   = act_min;
      assign hi   = act_max;

      always_comb begin
         res_next = y[OUT_W-1:0];
         sat_next = 1'b0;
         if (y < lo) begin
            res_next = act_min;
            sat_next = 1'b1;
         end else if (y > hi) begin
            res_next = act_max;
            sat_next = 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (!stall) begin
            a_reg   <= a_next;
            m_reg   <= mult_tab[idx];
            r1_reg  <= r_amt;
            p_reg   <= a64 * m64;
            r2_reg  <= r1_reg;
            ovf_reg <= (a_reg == 32'sh8000_0000) && (m_reg == 32'sh8000_0000);
            h_reg   <= h_next;
            r3_reg  <= r2_reg;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            res_reg <= '0;
            sat_reg <= 1'b0;
         end else if (!stall) begin
            res_reg <= res_next;
            sat_reg <= sat_next;
         end
      end

      assign out_data[gi*OUT_W +: OUT_W] = res_reg;
      assign sat_vec[gi] = sat_reg;
   end

`ifdef REQUANT_SAT_CNT_EN
   logic [31:0] sat_cnt_reg;
   logic [32:0] sat_sum;

   assign sat_sum = {1'b0, sat_cnt_reg} + 33'($countones(sat_vec));

   always_ff @(posedge clk) begin
      if (rst || sat_clr)
         sat_cnt_reg <= '0;
      else if (out_valid_reg && out_ready)
         sat_cnt_reg <= sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
   end

   assign sat_cnt = sat_cnt_reg;
`else
   logic unused_sat;
   assign unused_sat = sat_clr ^ (^sat_vec);
   assign sat_cnt    = '0;
`endif
endmodule

// File: tb/tb_requant_per_channel.sv
// Directed self-checking bench for requant_per_channel (LANES=4, OUT_W=8, CH_DEPTH=64).
module tb_requant_per_channel;
   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready, cfg_we, sat_clr;
   logic [127:0] in_data;
   logic [5:0]   in_ch, cfg_addr, cfg_shift;
   logic [31:0]  out_data, out_zp, cfg_mult, sat_cnt;
   logic [7:0]   act_min, act_max;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef REQUANT_SAT_CNT_EN
   localparam bit SAT_ON = 1'b1;
`else
   localparam bit SAT_ON = 1'b0;
`endif

   requant_per_channel dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ch(in_ch), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_zp(out_zp), .act_min(act_min), .act_max(act_max),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
      .sat_clr(sat_clr), .sat_cnt(sat_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
      return {32'(d), 32'(c), 32'(b), 32'(a)};
   endfunction

   function automatic logic [31:0] po(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [5:0] addr, input logic [31:0] m, input logic [5:0] s);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = addr; cfg_mult = m; cfg_shift = s;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Sends one beat and returns the first output seen plus its latency in cycles.
   task automatic beat(input logic [127:0] d, input logic [5:0] ch,
                       output logic [31:0] q, output int lat);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_ch = ch;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      q = out_data;
      $display("beat ch=%0d in=%h -> out=%h lat=%0d", ch, d, q, lat);
   endtask

   initial begin
      logic [31:0] q, q2, prev_data;
      int lat, sent, got, stall_cycles, vcount;
      logic prev_stall;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0; sat_clr = 1'b0;
      in_data = '0; in_ch = '0; cfg_addr = '0; cfg_mult = '0; cfg_shift = '0;
      out_zp = 32'd0; act_min = 8'h80; act_max = 8'h7F;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_sat_cnt", sat_cnt, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);

      // Identity table, latency
      beat(pk(100, 1, -2, 50), 6'd0, q, lat);
      chk("ident_lat", lat, 4);
      chk("ident_data", q, po(100, 1, -2, 50));

      // Rounding cases
      cfg(6'd0, 32'h4000_0000, 6'd0);
      beat(pk(5, 0, 0, 0), 6'd0, q, lat);
      chk("half_pos", q, po(3, 0, 0, 0));
      beat(pk(-6, 7, 0, 0), 6'd0, q, lat);
      chk("half_neg", q, po(-3, 7, 0, 0));
      cfg(6'd0, 32'h4000_0000, 6'h3F);
      beat(pk(12, 0, 0, 0), 6'd0, q, lat);
      chk("rshift1", q, po(3, 0, 0, 0));
      beat(pk(-10, 0, 0, 0), 6'd0, q, lat);
      chk("rshift1_neg", q, po(-3, 0, 0, 0));

      // Shift clamping on write: 31 -> 30, -32 -> -31
      cfg(6'd2, 32'h0000_0001, 6'd31);
      cfg(6'd3, 32'h4000_0000, 6'h20);
      beat(pk(1, 32'h4000_0000, 0, 0), 6'd2, q, lat);
      chk("shift_clamp", q, po(1, 0, 0, 0));
      chk("sat_pre", sat_cnt, 0);

      // Saturation and zero point
      beat(pk(1000, -1000, 127, -128), 6'd10, q, lat);
      chk("sat_data", q, po(127, -128, 127, -128));
      @(negedge clk);
      chk("sat_cnt1", sat_cnt, SAT_ON ? 32'd2 : 32'd0);
      out_zp = 32'd3; act_min = 8'hEC; act_max = 8'd20;
      beat(pk(100, -100, 5, -23), 6'd10, q, lat);
      chk("zp_clamp", q, po(20, -20, 8, -20));
      @(negedge clk);
      chk("sat_cnt2", sat_cnt, SAT_ON ? 32'd4 : 32'd0);
      sat_clr = 1'b1;
      @(negedge clk);
      sat_clr = 1'b0;
      chk("sat_clr", sat_cnt, 0);
      out_zp = 32'd0; act_min = 8'h80; act_max = 8'h7F;

      // Channel wrap
      cfg(6'd0, 32'h4000_0000, 6'd2);
      cfg(6'd1, 32'h4000_0000, 6'd2);
      beat(pk(10, 20, 30, 40), 6'd62, q, lat);
      chk("wrap", q, po(10, 20, 60, 80));

      // Back-to-back stream with a 3-cycle downstream stall
      sent = 0; got = 0; stall_cycles = 0; prev_stall = 1'b0; prev_data = '0;
      for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 6 && cyc <= 8);
         in_valid  = (sent < 10);
         in_data   = pk(sent, -sent, 2 * sent, sent + 50);
         in_ch     = 6'd20;
         #1;
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
         end
         if (out_valid && !out_ready) begin
            stall_cycles++;
            chk("stall_in_ready", in_ready, 0);
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            $display("stream out #%0d = %h", got, out_data);
            chk("stream_data", out_data, po(got, -got, 2 * got, got + 50));
            got++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("stream_count", got, 10);
      chk("stall_cycles", stall_cycles, 3);

      // Table write in the same cycle a beat reads the entry
      @(negedge clk);
      in_valid = 1'b1; in_data = pk(40, 0, 0, 0); in_ch = 6'd5;
      cfg_we = 1'b1; cfg_addr = 6'd5; cfg_mult = 32'h4000_0000; cfg_shift = 6'd0;
      @(negedge clk);
      cfg_we = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      q = out_data;
      @(negedge clk);
      q2 = out_data;
      $display("cfg race: old-beat %h new-beat %h", q, q2);
      chk("cfg_old", q, po(40, 0, 0, 0));
      chk("cfg_new_valid", out_valid, 1);
      chk("cfg_new", q2, po(20, 0, 0, 0));

      // Reset with beats in flight
      @(negedge clk);
      in_valid = 1'b1; in_data = pk(7, 7, 7, 7); in_ch = 6'd5;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_data", out_data, 0);
      rst = 1'b0; in_valid = 1'b0;
      vcount = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) vcount++;
         if (i == 0) chk("midrst_in_ready", in_ready, 1);
      end
      chk("midrst_stale", vcount, 0);
      beat(pk(40, 0, 0, 0), 6'd5, q, lat);
      chk("midrst_table", q, po(40, 0, 0, 0));
      chk("midrst_sat", sat_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/requant_per_channel.md
REQUANT_PER_CHANNEL -- requirements
Module: requant_per_channel

Interface
REQ-001 SHALL have parameter LANES, default 4: parallel 32-bit accumulators per beat, 1..16.
REQ-002 SHALL have parameter OUT_W, default 8: signed output width, 2..16.
REQ-003 SHALL have parameter CH_DEPTH, default 64: per-channel table entries, power of two, 2..256; AW = log2(CH_DEPTH).
REQ-004 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*32  signed accumulators; lane i is bits [32i+31:32i].
- in_ch  in  AW  channel of lane 0.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  LANES*OUT_W  signed results, same lane order as in_data.
- out_zp  in  32  signed output zero point, quasi-static.
- act_min / act_max  in  OUT_W each  signed clamp bounds, quasi-static; act_min <= act_max.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  AW  table address.
- cfg_mult  in  32  quantized multiplier.
- cfg_shift  in  6  signed shift.
- sat_clr  in  1  clear saturation counter.
- sat_cnt  out  32  saturated-lane count.

Function
REQ-005 Lane i SHALL use table entry (in_ch + i) mod CH_DEPTH; the index wraps past CH_DEPTH-1 to 0.
REQ-006 Per lane: L = max(shift,0), R = max(-shift,0); a = x << L, truncated to 32 bits (wrapping).
REQ-007 SRDHM: p = a*M as 64-bit signed; nudge = 2^30 if p >= 0, else 1-2^30; h = (p+nudge)/2^31, truncated toward zero; if a == M == 0x80000000, h = 0x7FFFFFFF.
REQ-008 Rounding divide: mask = 2^R-1; rem = h & mask; thr = mask>>1, plus 1 if h < 0; q = (h>>>R) + (rem > thr ? 1 : 0).
REQ-009 y = q + out_zp, computed in 33 bits; output is y clamped to [act_min, act_max].
REQ-010 cfg_shift outside -31..+30 SHALL be clamped to that range when written.
REQ-011 Pipeline SHALL have 4 stages: S1 table lookup and left shift; S2 64-bit multiply; S3 nudge and high word; S4 divide, zero point and clamp. Latency is exactly 4 cycles from accept to out_valid when unstalled.
REQ-012 Throughput SHALL be 1 beat per cycle. Stall = out_valid && !out_ready; stall freezes all stages; in_ready = !stall.
REQ-013 While out_valid is high, out_data SHALL remain stable until accepted; beats SHALL NOT be lost, duplicated or reordered.
REQ-014 A table write SHALL take effect from the next cycle. A beat sampling the same entry in the write cycle SHALL use the old value.
REQ-015 Beats already in flight SHALL keep the parameters sampled in S1.

Reset
REQ-016 On rst: all stage valids = 0, out_valid = 0, out_data = 0, sat_cnt = 0.
REQ-017 On rst: every table entry = {mult 0x40000000, shift +1}, which is the identity scale.
REQ-018 Reset SHALL take priority over stall and over cfg_we. In-flight beats are discarded. in_ready = 1 in the cycle after reset deasserts.

Configuration
REQ-019 With REQUANT_SAT_CNT_EN defined, sat_cnt SHALL add the number of lanes clamped (y < act_min or y > act_max) in each accepted output beat. It saturates at 0xFFFFFFFF. sat_clr zeroes it, taking priority over that cycle's increment.
REQ-020 Without REQUANT_SAT_CNT_EN, the sat_cnt port SHALL exist and be driven constant 0, and sat_clr is ignored.

Verification
REQ-021 After reset, out_zp=0, range [-128,127], lane0 x=100 -> out 100 exactly 4 cycles after accept.
REQ-022 Entry 0 = {0x40000000, 0}: x=5 -> 3; x=-6 -> -3. Entry 0 = {0x40000000, -1}: x=12 -> 3.
REQ-023 Identity table, x=1000 and x=-1000 -> 127 and -128; with the macro on, sat_cnt += 2; sat_clr -> 0.
REQ-024 LANES=4, in_ch=CH_DEPTH-2, entries 0 and 1 set to 2x scale -> lanes 2,3 double, lanes 0,1 unchanged.
REQ-025 10 back-to-back beats, out_ready low for 3 cycles mid-stream -> in_ready low during the stall, all 10 outputs in order, out_data held while stalled.
REQ-026 cfg_we to entry 5 in the same cycle a beat uses entry 5 -> that beat uses the old value, the next beat uses the new value; rst asserted mid-stream -> out_valid 0 next cycle, no stale beats emerge.
